// File: rtl/striping_ctrl_pkg.sv
// Shared physical-layer definitions for the two-lane striping path.
package striping_ctrl_pkg;

  // K28.5 replicated across all four bytes.
  localparam logic [31:0] PAD_WORD_DEFAULT = 32'hBCBC_BCBC;

  localparam int unsigned PAIR_CNT_W = 16;
  localparam int unsigned PAD_CNT_W  = 8;

  // IDLE: at a pair boundary. HALF: lane 0 issued, lane 1 owed.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HALF = 1'b1
  } stripe_state_e;

endpackage

// File: rtl/striping_ctrl_fifo.sv
// Synchronous input FIFO for the striping controller; head word is visible
// combinationally, occupancy is held in a register.
module striping_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  assign do_wr = wr_en && !full && !clear;
  assign do_rd = rd_en && !empty && !clear;

  // Next-state for storage, pointers and occupancy; clear wins over any access.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_wr && !do_rd) begin
        count_d = count_q + CW'(1);
      end else if (do_rd && !do_wr) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/striping_ctrl.sv
// Striping sequencer: issues buffered words as balanced lane-0/lane-1 pairs,
// padding the second half when no data is available.
module striping_ctrl
  import striping_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PAD_WORD = PAD_WORD_DEFAULT
) (
  input  logic        clk_2f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        in_ready,
  input  logic        enable,
  input  logic        flush,
  input  logic        stall,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        sel_out,
  output logic        pad_out,
  output logic [15:0] pair_cnt,
  output logic [7:0]  pad_cnt
);

  localparam logic [PAIR_CNT_W-1:0] PAIR_ONE = PAIR_CNT_W'(1);
  localparam logic [PAD_CNT_W-1:0]  PAD_ONE  = PAD_CNT_W'(1);

  stripe_state_e           state_q, state_d;
  logic [31:0]             data_out_q, data_out_d;
  logic                    valid_out_q, valid_out_d;
  logic                    sel_out_q, sel_out_d;
  logic                    pad_out_q, pad_out_d;
  logic [PAIR_CNT_W-1:0]   pair_cnt_q, pair_cnt_d;
  logic [PAD_CNT_W-1:0]    pad_cnt_q, pad_cnt_d;
  logic                    flush_pend_q, flush_pend_d;

  logic        fifo_full, fifo_empty, fifo_rd, fifo_clr, fifo_wr;
  logic [31:0] fifo_head;

  assign in_ready = !fifo_full;
  assign fifo_wr  = valid_in && in_ready;

  striping_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk_2f),
    .reset   (reset),
    .clear   (fifo_clr),
    .wr_en   (fifo_wr),
    .wr_data (data_in),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Pair sequencing, flush handling and statistics; stall freezes everything
  // on the issue side except capture of a late flush request.
  always_comb begin
    state_d      = state_q;
    data_out_d   = data_out_q;
    valid_out_d  = valid_out_q;
    sel_out_d    = sel_out_q;
    pad_out_d    = pad_out_q;
    pair_cnt_d   = pair_cnt_q;
    pad_cnt_d    = pad_cnt_q;
    flush_pend_d = flush_pend_q;
    fifo_rd      = 1'b0;
    fifo_clr     = 1'b0;

    if (stall) begin
      if (flush) begin
        flush_pend_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (flush || flush_pend_q) begin
            fifo_clr     = 1'b1;
            flush_pend_d = 1'b0;
            valid_out_d  = 1'b0;
          end else if (enable && !fifo_empty) begin
            fifo_rd     = 1'b1;
            data_out_d  = fifo_head;
            sel_out_d   = 1'b0;
            valid_out_d = 1'b1;
            pad_out_d   = 1'b0;
            state_d     = ST_HALF;
          end else begin
            valid_out_d = 1'b0;
            sel_out_d   = 1'b0;
            pad_out_d   = 1'b0;
          end
        end
        ST_HALF: begin
          if (!fifo_empty) begin
            fifo_rd    = 1'b1;
            data_out_d = fifo_head;
            pad_out_d  = 1'b0;
          end else begin
            data_out_d = PAD_WORD;
            pad_out_d  = 1'b1;
            if (pad_cnt_q != '1) begin
              pad_cnt_d = pad_cnt_q + PAD_ONE;
            end
          end
          sel_out_d   = 1'b1;
          valid_out_d = 1'b1;
          pair_cnt_d  = pair_cnt_q + PAIR_ONE;
          state_d     = ST_IDLE;
          // A started pair always completes; the flush waits for IDLE.
          if (flush) begin
            flush_pend_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered outputs, state and counters with synchronous reset.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      sel_out_q    <= 1'b0;
      pad_out_q    <= 1'b0;
      pair_cnt_q   <= '0;
      pad_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      sel_out_q    <= sel_out_d;
      pad_out_q    <= pad_out_d;
      pair_cnt_q   <= pair_cnt_d;
      pad_cnt_q    <= pad_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign sel_out   = sel_out_q;
  assign pad_out   = pad_out_q;
  assign pair_cnt  = pair_cnt_q;
  assign pad_cnt   = pad_cnt_q;

endmodule

// File: tb/tb_striping_ctrl.sv
// Directed bench for striping_ctrl with hand-computed expectations.
module tb_striping_ctrl;

  logic        clk_2f = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        in_ready;
  logic        enable;
  logic        flush;
  logic        stall;
  logic [31:0] data_out;
  logic        valid_out;
  logic        sel_out;
  logic        pad_out;
  logic [15:0] pair_cnt;
  logic [7:0]  pad_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  striping_ctrl #(
    .DEPTH    (4),
    .PAD_WORD (32'hBCBC_BCBC)
  ) dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .enable    (enable),
    .flush     (flush),
    .stall     (stall),
    .data_out  (data_out),
    .valid_out (valid_out),
    .sel_out   (sel_out),
    .pad_out   (pad_out),
    .pair_cnt  (pair_cnt),
    .pad_cnt   (pad_cnt)
  );

  always #5 clk_2f = ~clk_2f;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_in = 1'b0; data_in = '0;
    enable = 1'b1; flush = 1'b0; stall = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h exp 00000000", data_out); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", valid_out); end
    n_checks++; if (sel_out !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b exp 0", sel_out); end
    n_checks++; if (pad_out !== 1'b0) begin n_fail++; $display("FAIL reset_pad: got %b exp 0", pad_out); end
    n_checks++; if (pair_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_pair_cnt: got %0d exp 0", pair_cnt); end
    n_checks++; if (pad_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_pad_cnt: got %0d exp 0", pad_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
  endtask

  // A1..A4 back-to-back: one word per cycle, alternating lanes.
  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'hA1; exp_w[1] = 32'hA2; exp_w[2] = 32'hA3; exp_w[3] = 32'hA4;
    do_reset();
    valid_in = 1'b1; data_in = exp_w[0];
    step();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_latency: got valid %b exp 0", valid_out); end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin data_in = exp_w[i+1]; end
      else begin valid_in = 1'b0; end
      step();
      n_checks++; if (data_out !== exp_w[i] || valid_out !== 1'b1 || sel_out !== 1'(i % 2) || pad_out !== 1'b0)
        begin n_fail++; $display("FAIL b2b_word%0d: got %h v%b s%b p%b exp %h v1 s%0d p0", i, data_out, valid_out, sel_out, pad_out, exp_w[i], i % 2); end
    end
    n_checks++; if (pair_cnt !== 16'd2 || pad_cnt !== 8'd0) begin n_fail++; $display("FAIL b2b_counts: got pair %0d pad %0d exp 2 0", pair_cnt, pad_cnt); end
    step();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got valid %b exp 0", valid_out); end
  endtask

  // Single word completes with a pad.
  task automatic test_pad();
    do_reset();
    valid_in = 1'b1; data_in = 32'hB1;
    step();
    valid_in = 1'b0;
    step();
    n_checks++; if (data_out !== 32'hB1 || valid_out !== 1'b1 || sel_out !== 1'b0 || pad_out !== 1'b0)
      begin n_fail++; $display("FAIL pad_lane0: got %h v%b s%b p%b exp 000000b1 v1 s0 p0", data_out, valid_out, sel_out, pad_out); end
    step();
    n_checks++; if (data_out !== 32'hBCBC_BCBC || valid_out !== 1'b1 || sel_out !== 1'b1 || pad_out !== 1'b1)
      begin n_fail++; $display("FAIL pad_lane1: got %h v%b s%b p%b exp bcbcbcbc v1 s1 p1", data_out, valid_out, sel_out, pad_out); end
    n_checks++; if (pair_cnt !== 16'd1 || pad_cnt !== 8'd1) begin n_fail++; $display("FAIL pad_counts: got pair %0d pad %0d exp 1 1", pair_cnt, pad_cnt); end
    step();
    n_checks++; if (valid_out !== 1'b0 || pad_out !== 1'b0) begin n_fail++; $display("FAIL pad_after: got v%b p%b exp v0 p0", valid_out, pad_out); end
  endtask

  // Stall in HALF with C2 queued: outputs frozen, then C2 on lane 1.
  task automatic test_stall();
    do_reset();
    valid_in = 1'b1; data_in = 32'hC1;
    step();
    data_in = 32'hC2;
    step();
    valid_in = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (data_out !== 32'hC1 || valid_out !== 1'b1 || sel_out !== 1'b0 || pair_cnt !== 16'd0)
        begin n_fail++; $display("FAIL stall_hold%0d: got %h v%b s%b pair %0d exp 000000c1 v1 s0 pair 0", i, data_out, valid_out, sel_out, pair_cnt); end
    end
    stall = 1'b0;
    step();
    n_checks++; if (data_out !== 32'hC2 || sel_out !== 1'b1 || pad_out !== 1'b0 || pad_cnt !== 8'd0 || pair_cnt !== 16'd1)
      begin n_fail++; $display("FAIL stall_release: got %h s%b p%b pad %0d pair %0d exp 000000c2 s1 p0 pad 0 pair 1", data_out, sel_out, pad_out, pad_cnt, pair_cnt); end
  endtask

  // Fill with enable low, overflow write ignored, then drain exactly four words.
  task automatic test_full();
    do_reset();
    enable = 1'b0; valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 32'hD1 + 32'(i);
      step();
      if (i == 2) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_three: got in_ready %b exp 1", in_ready); end
      end
    end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got in_ready %b exp 0", in_ready); end
    data_in = 32'hD5;
    step();
    valid_in = 1'b0;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL full_no_issue: got valid %b exp 0", valid_out); end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (data_out !== 32'hD1 + 32'(i) || valid_out !== 1'b1 || sel_out !== 1'(i % 2) || pad_out !== 1'b0)
        begin n_fail++; $display("FAIL full_drain%0d: got %h v%b s%b p%b exp %h v1 s%0d p0", i, data_out, valid_out, sel_out, pad_out, 32'hD1 + 32'(i), i % 2); end
    end
    n_checks++; if (pair_cnt !== 16'd2 || pad_cnt !== 8'd0) begin n_fail++; $display("FAIL full_counts: got pair %0d pad %0d exp 2 0", pair_cnt, pad_cnt); end
    step();
    n_checks++; if (valid_out !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL full_fifth: got v%b rdy%b exp v0 rdy1", valid_out, in_ready); end
  endtask

  // Flush in HALF: pair completes, remaining word discarded at next IDLE edge.
  task automatic test_flush();
    do_reset();
    enable = 1'b0; valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 32'hE1 + 32'(i);
      step();
    end
    valid_in = 1'b0; enable = 1'b1;
    step();
    n_checks++; if (data_out !== 32'hE1 || sel_out !== 1'b0 || valid_out !== 1'b1) begin n_fail++; $display("FAIL flush_lane0: got %h s%b v%b exp 000000e1 s0 v1", data_out, sel_out, valid_out); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (data_out !== 32'hE2 || sel_out !== 1'b1 || pad_out !== 1'b0 || pair_cnt !== 16'd1)
      begin n_fail++; $display("FAIL flush_complete: got %h s%b p%b pair %0d exp 000000e2 s1 p0 pair 1", data_out, sel_out, pad_out, pair_cnt); end
    step();
    n_checks++; if (valid_out !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_applied: got v%b rdy%b exp v0 rdy1", valid_out, in_ready); end
    step();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_discard: got valid %b exp 0", valid_out); end
    valid_in = 1'b1; data_in = 32'hF1;
    step();
    valid_in = 1'b0;
    step();
    n_checks++; if (data_out !== 32'hF1 || sel_out !== 1'b0 || valid_out !== 1'b1) begin n_fail++; $display("FAIL flush_next: got %h s%b v%b exp 000000f1 s0 v1", data_out, sel_out, valid_out); end
  endtask

  // Build pair_cnt=5/pad_cnt=3, reset in HALF, then confirm clean restart.
  task automatic test_reset_mid_pair();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; data_in = 32'h100 + 32'(i);
      step();
      valid_in = 1'b0;
      step();
      step();
    end
    enable = 1'b0; valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 32'h200 + 32'(i);
      step();
    end
    valid_in = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) step();
    enable = 1'b0; valid_in = 1'b1;
    data_in = 32'h301; step();
    data_in = 32'h302; step();
    valid_in = 1'b0; enable = 1'b1;
    step();
    n_checks++; if (pair_cnt !== 16'd5 || pad_cnt !== 8'd3 || data_out !== 32'h301 || sel_out !== 1'b0)
      begin n_fail++; $display("FAIL rmid_setup: got pair %0d pad %0d %h s%b exp 5 3 00000301 s0", pair_cnt, pad_cnt, data_out, sel_out); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (data_out !== 32'h0 || valid_out !== 1'b0 || sel_out !== 1'b0 || pad_out !== 1'b0 || pair_cnt !== 16'd0 || pad_cnt !== 8'd0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL rmid_reset: got %h v%b s%b p%b pair %0d pad %0d rdy%b exp 0 v0 s0 p0 0 0 rdy1", data_out, valid_out, sel_out, pad_out, pair_cnt, pad_cnt, in_ready); end
    step();
    n_checks++; if (valid_out !== 1'b0 || pad_cnt !== 8'd0) begin n_fail++; $display("FAIL rmid_empty: got v%b pad %0d exp v0 pad 0", valid_out, pad_cnt); end
    valid_in = 1'b1; data_in = 32'h401;
    step();
    valid_in = 1'b0;
    step();
    n_checks++; if (data_out !== 32'h401 || sel_out !== 1'b0 || valid_out !== 1'b1) begin n_fail++; $display("FAIL rmid_restart: got %h s%b v%b exp 00000401 s0 v1", data_out, sel_out, valid_out); end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = '0;
    enable = 1'b0; flush = 1'b0; stall = 1'b0;
    #1;
    test_reset();
    test_back_to_back();
    test_pad();
    test_stall();
    test_full();
    test_flush();
    test_reset_mid_pair();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/striping_ctrl.md
# striping_ctrl

Sequencing controller that feeds the two-lane byte-striping demux in the PCIe physical-layer transmit path. It buffers 32-bit words from the link layer in a small FIFO. It issues them to the demux in strictly balanced lane-0/lane-1 pairs, inserting a pad word whenever the second half of a pair would otherwise be missing, so both lanes always carry the same word count. It also applies downstream stall, enable gating and flush, and keeps pair and pad statistics.

## Interface
Parameters:
- DEPTH, 4: input FIFO entries, power of two, 2..16.
- PAD_WORD, 32'hBCBC_BCBC: word inserted to complete a pair.

Ports:
- clk_2f  in  1  double-rate striping clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- data_in  in  32  word from the link layer.
- valid_in  in  1  data_in valid; written only when in_ready=1.
- in_ready  out  1  high when the FIFO is not full.
- enable  in  1  permits starting new pairs.
- flush  in  1  single-cycle request to discard FIFO contents.
- stall  in  1  downstream hold; freezes the issue side.
- data_out  out  32  word to the demux data input.
- valid_out  out  1  word valid toward the demux.
- sel_out  out  1  target lane: 0 = lane 0, 1 = lane 1.
- pad_out  out  1  current data_out is PAD_WORD, not link data.
- pair_cnt  out  16  completed pairs, wraps 0xFFFF→0.
- pad_cnt  out  8  inserted pads, saturates at 255.

## Operation
- FSM states: IDLE (pair boundary), HALF (lane 0 issued, lane 1 owed).
- Every edge with stall=1: state, FIFO read side, all outputs and counters hold. FIFO writes still occur.
- IDLE, stall=0:
  - If flush or flush_pend is set: FIFO cleared, flush_pend cleared, valid_out←0, stay in IDLE.
  - Else if enable=1 and the FIFO is not empty: pop. data_out←head, sel_out←0, valid_out←1, pad_out←0, go to HALF.
  - Else: valid_out←0, sel_out←0, pad_out←0.
- HALF, stall=0:
  - If the FIFO is not empty: pop. data_out←head, pad_out←0.
  - Else: data_out←PAD_WORD, pad_out←1, pad_cnt+1.
  - In both cases sel_out←1, valid_out←1, pair_cnt+1, go to IDLE.
  - enable is ignored in HALF; a started pair always completes.
- A flush arriving in HALF (or while stalled) sets flush_pend. It is applied at the next IDLE, non-stall edge.
- FIFO write: a word is written when valid_in=1 and in_ready=1. in_ready = !full, computed from the registered occupancy.
  - A write and a pop on the same edge are legal and leave the count unchanged.
  - When full, in_ready=0 even if a pop occurs on the same edge.
  - A write on an edge where a flush is applied is discarded.
- Reset, including mid-pair: FIFO empty, state IDLE, flush_pend 0. data_out, valid_out, sel_out, pad_out, pair_cnt and pad_cnt all 0. in_ready=1 after the reset edge. No pad is issued for an interrupted pair.

## Timing
- Latency: a word written at edge k into an empty FIFO, with state IDLE, enable=1 and stall=0, appears on data_out/valid_out after edge k+1.
- Outputs are registered, except in_ready, which is combinational from the occupancy register.
- Balance invariant: every lane-0 issue is followed, at the next non-stall edge, by exactly one lane-1 issue. Consecutive valid_out words always alternate sel_out 0,1,0,1.
- Sustained throughput: one word per clk_2f cycle, i.e. one pair per two cycles.

## Structure
- Shared physical-layer package holds: PAD_WORD default (K28.5 replicated), FSM state encoding (IDLE, HALF), and counter widths (16, 8).
- One sub-module, striping_fifo: synchronous FIFO with DEPTH entries, wr_en/rd_en/full/empty/clear and registered count, reset synchronous active-high.
- striping_ctrl holds the FSM, output registers, flush_pend and the counters.

## Test plan
- Stream A1,A2,A3,A4 back-to-back, enable=1 → data_out A1/sel 0, A2/sel 1, A3/sel 0, A4/sel 1; pair_cnt=2, pad_cnt=0.
- Single word B1 then idle → B1/sel 0, then BCBCBCBC/sel 1 with pad_out=1; pair_cnt=1, pad_cnt=1; valid_out=0 afterwards.
- Assert stall for 3 cycles while in HALF with C2 queued → outputs frozen for 3 cycles, then C2/sel 1; no pad issued.
- Fill 4 words with enable=0 → in_ready=0 and a 5th write is ignored. Raise enable → exactly 4 words issue, in 2 pairs.
- Pulse flush in HALF with 2 words queued → the pair completes with the next word, the remaining word is discarded, in_ready=1, and no further valid_out.
- Assert reset in HALF with counters at pair_cnt=5, pad_cnt=3 → all outputs 0 and the FIFO empty after that edge. The next word issues on lane 0.
